// File: rtl/mult_share_pkg.sv
//============================================================================
// Module      : mult_share_pkg
// Description : Shared types and helpers for the multiplier-sharing scheduler.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package mult_share_pkg;

    // Sized for the largest supported requester count (8).
    localparam int c_MAX_REQ   = 8;
    localparam int c_TAG_IDX_W = 3;

    typedef struct packed {
        logic                   valid;
        logic [c_TAG_IDX_W-1:0] idx;
    } tag_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [c_MAX_REQ-1:0] onehot(input logic [c_TAG_IDX_W-1:0] idx,
                                                    input int n);
        logic [c_MAX_REQ-1:0] v;
        v = '0;
        if (int'(idx) < n) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb.sv
//============================================================================
// Module      : rr_arb
// Description : Pointer-based round-robin arbiter, one grant per cycle.
//               MULT_SHARE_PRIO0_EN gives requester 0 strict priority.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_j;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_nxt;
    logic             w_found;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_j     = '0;
`ifdef MULT_SHARE_PRIO0_EN
        if (i_req[0]) begin
            w_found = 1'b1;
        end
`endif
        for (int k = 0; k < N; k++) begin
            w_j = IDX_W'((int'(r_ptr) + k) % N);
            if (!w_found && i_req[w_j]) begin
                w_found = 1'b1;
                w_idx   = w_j;
            end
        end
        // Nothing is granted while reset is held.
        o_any = w_found && !rst;
        o_idx = w_idx;
        o_gnt = '0;
        if (o_any) begin
            o_gnt[w_idx] = 1'b1;
        end
    end

    assign w_nxt = (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_any) begin
`ifdef MULT_SHARE_PRIO0_EN
            if (w_idx != '0) begin
                r_ptr <= w_nxt;
            end
`else
            r_ptr <= w_nxt;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_share_sched.sv
//============================================================================
// Module      : mult_share_sched
// Description : Shares one external pipelined signed multiplier between
//               N_REQ requesters; option macro MULT_SHARE_PRIO0_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int WIDTH_A = 16,
    parameter  int WIDTH_B = 16,
    parameter  int LATENCY = 1,
    localparam int WIDTH_P = WIDTH_A + WIDTH_B
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH_A-1:0] req_a,
    input  logic [N_REQ*WIDTH_B-1:0] req_b,
    output logic                     mul_ce,
    output logic [WIDTH_A-1:0]       mul_a,
    output logic [WIDTH_B-1:0]       mul_b,
    input  logic [WIDTH_P-1:0]       mul_p,
    output logic [N_REQ-1:0]         res_valid,
    output logic [WIDTH_P-1:0]       res_p,
    output logic                     busy
);

    localparam int IDX_W = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);

    logic [N_REQ-1:0]   w_gnt;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_xfer;
    logic               w_tag_any;
    logic               w_ce;
    tag_t               w_last;

    logic [WIDTH_A-1:0] r_mul_a;
    logic [WIDTH_B-1:0] r_mul_b;
    tag_t               r_tag [LATENCY+1];
    logic [N_REQ-1:0]   r_res_valid;
    logic [WIDTH_P-1:0] r_res_p;

    rr_arb #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk   (CLK),
        .rst   (RST),
        .i_req (req_valid),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_xfer)
    );

    always_comb begin
        w_tag_any = 1'b0;
        for (int k = 0; k <= LATENCY; k++) begin
            w_tag_any = w_tag_any | r_tag[k].valid;
        end
    end

    // The enable drops only once the pipeline is empty, so freezing loses nothing.
    assign w_ce   = !RST && (w_xfer || w_tag_any);
    assign w_last = r_tag[LATENCY];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_xfer) begin
            r_mul_a <= req_a[w_gidx*WIDTH_A +: WIDTH_A];
            r_mul_b <= req_b[w_gidx*WIDTH_B +: WIDTH_B];
        end
    end

    // Tag k travels in step with multiplier register stage k.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k <= LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else if (w_ce) begin
            r_tag[0].valid <= w_xfer;
            r_tag[0].idx   <= c_TAG_IDX_W'(w_gidx);
            for (int k = 1; k <= LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_res_valid <= '0;
            r_res_p     <= '0;
        end else if (w_last.valid && w_ce) begin
            r_res_valid <= N_REQ'(onehot(w_last.idx, N_REQ));
            r_res_p     <= mul_p;
        end else begin
            r_res_valid <= '0;
        end
    end

    assign req_ready = w_gnt;
    assign mul_ce    = w_ce;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign res_valid = r_res_valid;
    assign res_p     = r_res_p;
    assign busy      = !RST && (w_tag_any || (|r_res_valid));

endmodule

`default_nettype wire

// File: tb/tb_mult_share_sched.sv
//============================================================================
// Module      : tb_mult_share_sched
// Description : Scoreboard bench for mult_share_sched with a behavioural
//               multiplier and arbitration reference model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mult_share_sched;

    localparam int N  = 4;
    localparam int WA = 16;
    localparam int WB = 16;
    localparam int L  = 1;
    localparam int WP = WA + WB;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*WA-1:0] req_a;
    logic [N*WB-1:0] req_b;
    logic            mul_ce;
    logic [WA-1:0]   mul_a;
    logic [WB-1:0]   mul_b;
    logic [WP-1:0]   mul_p;
    logic [N-1:0]    res_valid;
    logic [WP-1:0]   res_p;
    logic            busy;

    always #5 CLK = ~CLK;

    mult_share_sched #(
        .N_REQ   (N),
        .WIDTH_A (WA),
        .WIDTH_B (WB),
        .LATENCY (L)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_ce    (mul_ce),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .res_valid (res_valid),
        .res_p     (res_p),
        .busy      (busy)
    );

    // External multiplier: L clock-enabled register stages.
    logic [WP-1:0] mpipe [L];
    always @(posedge CLK) begin
        if (mul_ce) begin
            mpipe[0] <= $signed(mul_a) * $signed(mul_b);
            for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mul_p = mpipe[L-1];

    typedef struct {
        int          idx;
        logic [31:0] p;
        int          due;
    } exp_t;

    exp_t               q[$];
    exp_t               e;
    int                 tests = 0;
    int                 fails = 0;
    int                 cyc   = 0;
    int                 mptr  = 0;
    int                 seen3 = 0;
    bit                 mon_en = 1'b0;
    logic [31:0]        last_p = '0;
    logic [N-1:0]       v;
    logic signed [15:0] av [N];
    logic signed [15:0] bv [N];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] prod(input logic signed [15:0] a, input logic signed [15:0] b);
        int r;
        r = int'(a) * int'(b);
        return r;
    endfunction

    // Reference arbitration: who should win given the requests now visible.
    function automatic int pick();
`ifdef MULT_SHARE_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    task automatic apply();
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_a[i*WA +: WA] = av[i];
            req_b[i*WB +: WB] = bv[i];
        end
    endtask

    // One clock: check the grant, log the expected result, retire the winner.
    task automatic step(input bit hold);
        int   g;
        exp_t t;
        @(negedge CLK);
        if (req_ready[3]) seen3++;
        if (RST) begin
            check("ready_in_reset", req_ready, 0);
            mptr = 0;
            q.delete();
            g = -1;
        end else begin
            g = pick();
            check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            if (g >= 0) begin
                t.idx = g;
                t.p   = prod(av[g], bv[g]);
                t.due = cyc + L + 2;
                q.push_back(t);
`ifdef MULT_SHARE_PRIO0_EN
                if (g != 0) mptr = (g + 1) % N;
`else
                mptr = (g + 1) % N;
`endif
            end
        end
        @(posedge CLK);
        #1;
        if (g >= 0 && !hold) v[g] = 1'b0;
        apply();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            step(1'b0);
            n++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    always @(negedge CLK) begin
        if (!RST && mon_en) begin
            if (res_valid != '0) begin
                if (q.size() == 0) begin
                    check("unexpected_res_valid", res_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("res_valid", res_valid, 64'd1 << e.idx);
                    check("res_p", res_p, e.p);
                    check("res_latency", cyc, e.due);
                    last_p = e.p;
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                check("res_missing", cyc, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        v   = '0;
        for (int i = 0; i < N; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        apply();
        repeat (3) @(posedge CLK);
        #1;
        v = '1;
        apply();
        @(negedge CLK);
        check("rst_req_ready", req_ready, 0);
        check("rst_mul_ce", mul_ce, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_p", res_p, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        @(posedge CLK);
        #1;
        v = '0;
        apply();
        RST    = 1'b0;
        mon_en = 1'b1;

        // All four requesting continuously: strict rotation.
        for (int i = 0; i < N; i++) begin
            av[i] = 16'(i + 1);
            bv[i] = 16'sd10;
        end
        v = '1;
        apply();
        repeat (8) step(1'b1);
        v = '0;
        apply();
        drain();

        // Single requester 2.
        av[2] = 16'sd3;
        bv[2] = -16'sd5;
        v[2]  = 1'b1;
        apply();
        step(1'b0);
        drain();
        check("single_req2_product", last_p, 32'hFFFF_FFF1);

        // Extreme operands.
        av[1] = -16'sd32768;
        bv[1] = -16'sd32768;
        v[1]  = 1'b1;
        apply();
        step(1'b0);
        drain();
        check("extreme_neg_neg", last_p, 32'h4000_0000);
        av[3] = 16'sd32767;
        bv[3] = -16'sd32768;
        v[3]  = 1'b1;
        apply();
        step(1'b0);
        drain();
        check("extreme_pos_neg", last_p, 32'hC000_8000);

        // Randomized traffic.
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i]  = 1'b1;
                    av[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                    bv[i] = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
                end
            end
            apply();
            step(1'b0);
        end
        v = '0;
        apply();
        drain();

        // Idle after drain.
        repeat (5) step(1'b0);
        @(negedge CLK);
        check("idle_mul_ce", mul_ce, 0);
        check("idle_busy", busy, 0);
        check("idle_res_valid", res_valid, 0);
        check("idle_res_p_hold", res_p, last_p);
        @(posedge CLK);
        #1;

        // Reset one cycle after issuing requester 1.
        av[1] = 16'sd7;
        bv[1] = 16'sd9;
        v[1]  = 1'b1;
        apply();
        step(1'b0);
        RST = 1'b1;
        step(1'b0);
        step(1'b0);
        RST = 1'b0;
        repeat (4) step(1'b0);
        for (int i = 0; i < N; i++) begin
            av[i] = 16'(100 + i);
            bv[i] = -16'sd3;
        end
        v = '1;
        apply();
        #1;
        check("post_reset_grant", req_ready, 4'b0001);
        repeat (4) step(1'b0);
        drain();

`ifdef MULT_SHARE_PRIO0_EN
        // Requester 0 holds priority over requester 3.
        av[0] = 16'sd2;
        bv[0] = 16'sd4;
        av[3] = 16'sd5;
        bv[3] = 16'sd6;
        v[0]  = 1'b1;
        v[3]  = 1'b1;
        apply();
        seen3 = 0;
        repeat (20) step(1'b1);
        check("prio_req3_starved", seen3, 0);
        v[0] = 1'b0;
        apply();
        #1;
        check("prio_req3_granted", req_ready, 4'b1000);
        step(1'b0);
        drain();
`endif

        repeat (3) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
